// File: rtl/mem_burst_responder.sv
// Memory-side responder for the IMEM/DMEM bus.
// Serves single-word and 4/8/16-word bursts on a big-endian word array.
module mem_burst_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h80020000,
    parameter int          MEMORY_DEPTH = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic [1:0]  access_size,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        do_wm_bypass,
    input  logic [31:0] wm_bypass,
    output logic [31:0] data_out,
    output logic        rd_valid,
    output logic        busy,
    output logic        error
);

    localparam int          WORDS = MEMORY_DEPTH / 4;
    localparam int          IDX_W = $clog2(WORDS);
    localparam logic [32:0] TOP   = {1'b0, BASE_ADDR} + 33'(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST
    } state_t;

    state_t      r_state;
    logic        r_rw;
    logic [31:0] r_base;
    logic [3:0]  r_beat;
    logic [3:0]  r_last;

    // Words are stored whole; byte o of a word is bits [31-8*(o%4) -: 8].
    logic [31:0] r_mem [WORDS];

    logic             w_accept;
    logic             w_active;
    logic             w_beat_rw;
    logic [31:0]      w_addr;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_inrange;
    logic [31:0]      w_wdata;
    logic             w_we;
    logic [3:0]       w_n_last;
    logic             w_unused;

    assign w_accept  = (r_state == IDLE) && enable;
    assign w_active  = w_accept || (r_state != IDLE);
    assign w_beat_rw = (r_state == IDLE) ? rw : r_rw;

    // Beat 0 uses the live request; later beats use the latched base.
    assign w_addr = (r_state == IDLE)
                  ? {address[31:2], 2'b00}
                  : r_base + {26'd0, r_beat, 2'b00};

    assign w_off     = w_addr - BASE_ADDR;
    assign w_idx     = w_off[IDX_W+1:2];
    assign w_inrange = (w_addr >= BASE_ADDR)
                    && (({1'b0, w_addr} + 33'd3) < TOP);
    assign w_unused  = ^{w_off[31:IDX_W+2], w_off[1:0]};

    assign w_wdata = do_wm_bypass ? wm_bypass : data_in;
    assign w_we    = w_active && !w_beat_rw && w_inrange;

    always_comb begin
        w_n_last = 4'd0;
        unique case (access_size)
            2'b00: w_n_last = 4'd0;
            2'b01: w_n_last = 4'd3;
            2'b10: w_n_last = 4'd7;
            2'b11: w_n_last = 4'd15;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset && w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rw     <= 1'b0;
            r_base   <= 32'd0;
            r_beat   <= 4'd0;
            r_last   <= 4'd0;
            data_out <= 32'd0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            error    <= 1'b0;
            if (w_active) begin
                error <= !w_inrange;
                if (w_beat_rw) begin
                    rd_valid <= 1'b1;
                    data_out <= w_inrange ? r_mem[w_idx] : 32'd0;
                end
            end
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_rw   <= rw;
                        r_base <= {address[31:2], 2'b00};
                        r_beat <= 4'd1;
                        r_last <= w_n_last;
                        if (w_n_last != 4'd0) begin
                            r_state <= rw ? RD_BURST : WR_BURST;
                            busy    <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (r_beat == r_last) begin
                        r_state <= IDLE;
                        r_beat  <= 4'd0;
                        busy    <= 1'b0;
                    end else begin
                        r_beat <= r_beat + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: single, burst, range, reset-abort
// and bypass scenarios with hand-computed expectations.
module tb_mem_burst_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        rw;
    logic [1:0]  access_size;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        do_wm_bypass;
    logic [31:0] wm_bypass;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        busy;
    logic        error;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mem_burst_responder dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .rw           (rw),
        .access_size  (access_size),
        .address      (address),
        .data_in      (data_in),
        .do_wm_bypass (do_wm_bypass),
        .wm_bypass    (wm_bypass),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .error        (error)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic r, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        enable      = 1'b1;
        rw          = r;
        access_size = sz;
        address     = a;
        data_in     = d;
        tick;
        enable = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
        acc(1'b1, 2'b00, a, 32'd0);
        chk({tag, "_data"}, data_out, exp);
        chk({tag, "_rv"}, {31'd0, rd_valid}, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        rw           = 1'b0;
        access_size  = 2'b00;
        address      = 32'd0;
        data_in      = 32'd0;
        do_wm_bypass = 1'b0;
        wm_bypass    = 32'd0;
        tick;
        tick;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rv", {31'd0, rd_valid}, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        reset = 1'b0;

        // 1: single write then single read
        acc(1'b0, 2'b00, 32'h80020000, 32'hDEADBEEF);
        chk("t1_wr_busy", {31'd0, busy}, 32'd0);
        chk("t1_wr_err", {31'd0, error}, 32'd0);
        chk("t1_wr_rv", {31'd0, rd_valid}, 32'd0);
        acc(1'b1, 2'b00, 32'h80020000, 32'd0);
        chk("t1_rd_data", data_out, 32'hDEADBEEF);
        chk("t1_rd_rv", {31'd0, rd_valid}, 32'd1);
        chk("t1_rd_busy", {31'd0, busy}, 32'd0);
        chk("t1_rd_err", {31'd0, error}, 32'd0);
        tick;
        chk("t1_idle_rv", {31'd0, rd_valid}, 32'd0);
        chk("t1_hold", data_out, 32'hDEADBEEF);

        // 2: preload then 4-word read with ignored requests while busy
        acc(1'b0, 2'b00, 32'h80020010, 32'h11);
        acc(1'b0, 2'b00, 32'h80020014, 32'h22);
        acc(1'b0, 2'b00, 32'h80020018, 32'h33);
        acc(1'b0, 2'b00, 32'h8002001C, 32'h44);
        acc(1'b1, 2'b01, 32'h80020010, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t2_data%0d", k), data_out, 32'(k * 32'h11));
            chk($sformatf("t2_rv%0d", k), {31'd0, rd_valid}, 32'd1);
            chk($sformatf("t2_busy%0d", k), {31'd0, busy},
                (k <= 3) ? 32'd1 : 32'd0);
            if (k <= 3) begin
                enable      = 1'b1;
                rw          = 1'b0;
                access_size = 2'b00;
                address     = 32'h80020010;
                data_in     = 32'd0;
                tick;
            end
        end
        enable = 1'b0;
        rd1("t2_ignored", 32'h80020010, 32'h11);

        // 3: 8-word write burst, then 8-word read accepted in cycle 8
        acc(1'b0, 2'b10, 32'h80020100, 32'hA0);
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("t3_wbusy%0d", k), {31'd0, busy}, 32'd1);
            data_in = 32'hA0 + 32'(k);
            address = 32'h80020000;
            rw      = 1'b1;
            tick;
        end
        chk("t3_wbusy8", {31'd0, busy}, 32'd0);
        acc(1'b1, 2'b10, 32'h80020100, 32'd0);
        for (int k = 0; k <= 7; k++) begin
            chk($sformatf("t3_rdata%0d", k), data_out, 32'hA0 + 32'(k));
            chk($sformatf("t3_rerr%0d", k), {31'd0, error}, 32'd0);
            tick;
        end
        chk("t3_rbusy_end", {31'd0, busy}, 32'd0);

        // 4: unaligned address and below-base access
        rd1("t4_unal", 32'h80020002, 32'hDEADBEEF);
        acc(1'b1, 2'b00, 32'h8001FFFC, 32'd0);
        chk("t4_low_data", data_out, 32'd0);
        chk("t4_low_err", {31'd0, error}, 32'd1);
        chk("t4_low_rv", {31'd0, rd_valid}, 32'd1);
        acc(1'b0, 2'b00, 32'h8001FFFC, 32'h12345678);
        chk("t4_low_werr", {31'd0, error}, 32'd1);
        chk("t4_low_wrv", {31'd0, rd_valid}, 32'd0);

        // 5: 16-word read crossing the top of memory
        acc(1'b0, 2'b00, 32'h8011FFF8, 32'h5A5A0001);
        acc(1'b0, 2'b00, 32'h8011FFFC, 32'h5A5A0002);
        acc(1'b1, 2'b11, 32'h8011FFF8, 32'd0);
        for (int k = 0; k <= 15; k++) begin
            chk($sformatf("t5_data%0d", k), data_out,
                (k == 0) ? 32'h5A5A0001 : (k == 1) ? 32'h5A5A0002 : 32'd0);
            chk($sformatf("t5_err%0d", k), {31'd0, error},
                (k < 2) ? 32'd0 : 32'd1);
            chk($sformatf("t5_rv%0d", k), {31'd0, rd_valid}, 32'd1);
            tick;
        end
        chk("t5_busy_end", {31'd0, busy}, 32'd0);

        // 6: reset mid-burst, then bypassed write
        acc(1'b0, 2'b00, 32'h80020208, 32'h77);
        acc(1'b0, 2'b11, 32'h80020200, 32'hB0);
        data_in = 32'hB1;
        tick;
        data_in = 32'hB2;
        reset   = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_dout", data_out, 32'd0);
        tick;
        rd1("t6_b0", 32'h80020200, 32'hB0);
        rd1("t6_b1", 32'h80020204, 32'hB1);
        rd1("t6_b2", 32'h80020208, 32'h77);

        do_wm_bypass = 1'b1;
        wm_bypass    = 32'hCAFE0001;
        acc(1'b0, 2'b00, 32'h80020300, 32'h12345678);
        do_wm_bypass = 1'b0;
        rd1("t6_byp", 32'h80020300, 32'hCAFE0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
